// File: rtl/rename_alias_table.sv
// Four-wide register alias table: renames up to four instructions per cycle,
// keeps a committed map that restores the speculative map on flush.
// Ports: stall/flush control, per-slot arch indices and free PRs in,
// registered src/dst/old_dst PRs and ren_vld out, pr_need_inst_out to the
// free list, commit mappings in, rat_stall out.
// Option: RAT_FL_EMPTY_STALL_EN blocks renaming while the free list is empty.
module rename_alias_table #(
   parameter int AR_W = 4,
   parameter int PR_W = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall,
   input  logic              flush,
   input  logic [3:0]        inst_vld,
   input  logic [3:0]        dst_wr,
   input  logic [4*AR_W-1:0] src1_arch,
   input  logic [4*AR_W-1:0] src2_arch,
   input  logic [4*AR_W-1:0] dst_arch,
   input  logic [4*PR_W-1:0] pr_num_in,
   input  logic              list_empty,
   output logic [3:0]        pr_need_inst_out,
   input  logic [3:0]        cmt_vld,
   input  logic [4*AR_W-1:0] cmt_arch,
   input  logic [4*PR_W-1:0] cmt_pr,
   output logic [3:0]        ren_vld,
   output logic [4*PR_W-1:0] src1_pr,
   output logic [4*PR_W-1:0] src2_pr,
   output logic [4*PR_W-1:0] dst_pr,
   output logic [4*PR_W-1:0] old_dst_pr,
   output logic              rat_stall
);
   localparam int NA = 1 << AR_W;

   logic [PR_W-1:0]   spec_q [NA];
   logic [PR_W-1:0]   spec_d [NA];
   logic [PR_W-1:0]   cmt_q  [NA];
   logic [PR_W-1:0]   cmt_d  [NA];
   logic [3:0]        vld_q;
   logic [4*PR_W-1:0] s1_q, s2_q, dp_q, od_q;
   logic [4*PR_W-1:0] s1_d, s2_d, dp_d, od_d;
   logic [PR_W-1:0]   new_pr [4];
   logic [3:0]        need;
   logic              blk;
   logic              fire;

   assign need = inst_vld & dst_wr;

`ifdef RAT_FL_EMPTY_STALL_EN
   assign blk = list_empty && (|need);
`else
   logic unused_list_empty;
   assign unused_list_empty = list_empty;
   assign blk = 1'b0;
`endif

   assign fire             = !stall && !flush && !blk;
   assign rat_stall        = blk;
   assign pr_need_inst_out = fire ? need : 4'b0000;

   // Compacted allocation: n-th needing slot takes the n-th free PR.
   always_comb begin
      int cnt;
      cnt = 0;
      for (int k = 0; k < 4; k++) begin
         new_pr[k] = pr_num_in[cnt*PR_W +: PR_W];
         if (need[k]) cnt = cnt + 1;
      end
   end

   // Map lookup with bypass from older writers in the group; scanning j
   // upward leaves the nearest older writer as the winner.
   always_comb begin
      logic [AR_W-1:0] a1, a2, ad;
      s1_d = '0;
      s2_d = '0;
      dp_d = '0;
      od_d = '0;
      for (int k = 0; k < 4; k++) begin
         a1 = src1_arch[k*AR_W +: AR_W];
         a2 = src2_arch[k*AR_W +: AR_W];
         ad = dst_arch[k*AR_W +: AR_W];
         s1_d[k*PR_W +: PR_W] = spec_q[a1];
         s2_d[k*PR_W +: PR_W] = spec_q[a2];
         od_d[k*PR_W +: PR_W] = spec_q[ad];
         for (int j = 0; j < 4; j++) begin
            if (j < k && need[j]) begin
               if (dst_arch[j*AR_W +: AR_W] == a1)
                  s1_d[k*PR_W +: PR_W] = new_pr[j];
               if (dst_arch[j*AR_W +: AR_W] == a2)
                  s2_d[k*PR_W +: PR_W] = new_pr[j];
               if (dst_arch[j*AR_W +: AR_W] == ad)
                  od_d[k*PR_W +: PR_W] = new_pr[j];
            end
         end
         if (need[k]) begin
            dp_d[k*PR_W +: PR_W] = new_pr[k];
         end else begin
            od_d[k*PR_W +: PR_W] = '0;
         end
      end
   end

   // Commit map, later slots win; flush copies it including this cycle's commits.
   always_comb begin
      for (int i = 0; i < NA; i++) begin
         cmt_d[i]  = cmt_q[i];
         spec_d[i] = spec_q[i];
      end
      for (int k = 0; k < 4; k++) begin
         if (cmt_vld[k])
            cmt_d[cmt_arch[k*AR_W +: AR_W]] = cmt_pr[k*PR_W +: PR_W];
      end
      if (flush) begin
         for (int i = 0; i < NA; i++) spec_d[i] = cmt_d[i];
      end else if (fire) begin
         for (int k = 0; k < 4; k++) begin
            if (need[k]) spec_d[dst_arch[k*AR_W +: AR_W]] = new_pr[k];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NA; i++) begin
            spec_q[i] <= PR_W'(i);
            cmt_q[i]  <= PR_W'(i);
         end
      end else begin
         for (int i = 0; i < NA; i++) begin
            spec_q[i] <= spec_d[i];
            cmt_q[i]  <= cmt_d[i];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
         s1_q  <= '0;
         s2_q  <= '0;
         dp_q  <= '0;
         od_q  <= '0;
      end else if (fire) begin
         vld_q <= inst_vld;
         s1_q  <= s1_d;
         s2_q  <= s2_d;
         dp_q  <= dp_d;
         od_q  <= od_d;
      end else if (!stall) begin
         vld_q <= '0;
      end
   end

   assign ren_vld    = vld_q;
   assign src1_pr    = s1_q;
   assign src2_pr    = s2_q;
   assign dst_pr     = dp_q;
   assign old_dst_pr = od_q;
endmodule

// File: doc/rename_alias_table.md
# rename_alias_table

Four-wide register alias table (RAT) for the rename stage. It maps architectural source and destination registers of up to four decoded instructions per cycle to physical registers, consuming the physical registers offered by the free list. It reports the previous mapping of each destination to the reorder buffer so that register can be freed later. It also keeps a committed map that restores the speculative map on flush.

## Interface
Parameters:
- AR_W, 4: architectural register index width (16 architectural registers).
- PR_W, 6: physical register index width (64 physical registers).

Ports (slot k occupies bits [k*W +: W] of each packed bus; slot 0 is oldest):
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- stall  input  1  backend stall; holds all rename state and outputs.
- flush  input  1  mispredict flush; restores the speculative map from the committed map.
- inst_vld  input  4  slot holds a valid instruction.
- dst_wr  input  4  slot writes a destination register.
- src1_arch, src2_arch, dst_arch  input  4*AR_W  architectural indices.
- pr_num_in  input  4*PR_W  free physical registers from the free list, in allocation order.
- list_empty  input  1  free list cannot supply four registers.
- pr_need_inst_out  output  4  slots consuming a new physical register; drives the free list's pr_need_inst_in.
- cmt_vld  input  4  committing instructions with a destination, in program order.
- cmt_arch  input  4*AR_W, cmt_pr  input  4*PR_W  committed mappings.
- ren_vld  output  4  registered renamed-slot valid.
- src1_pr, src2_pr, dst_pr, old_dst_pr  output  4*PR_W  registered rename results.
- rat_stall  output  1  rename blocked because the free list is empty (see Configuration).

## Operation
- State:
  - spec_map[16] and cmt_map[16], each PR_W wide.
  - On reset, entry i of both maps is set to i.
  - All outputs reset to 0.
- Fire condition: fire = !stall && !flush && !blk, where blk = rat_stall.
- pr_need_inst_out = inst_vld & dst_wr when fire is true; otherwise 4'b0000. This output is combinational.
- Allocation is compacted:
  - The n-th slot (counting from 0) with its need bit set receives pr_num_in[n].
  - Example: need = 4'b1010 gives slot1 pr_num_in[0] and slot3 pr_num_in[1].
- Source lookup for slot k:
  - If the nearest older slot j<k in the same group writes the same architectural register, the source is slot j's new PR.
  - Otherwise the source is spec_map[src].
- old_dst_pr for slot k:
  - Same search as the source lookup, applied to dst_arch.
  - Reported for writing slots only; non-writing slots output 0.
- spec_map update on fire: every writing slot updates its entry, and the youngest writer of a given architectural register wins.
- Commit:
  - Each cycle, regardless of stall or flush, cmt_map[cmt_arch[k]] <= cmt_pr[k] for each valid k.
  - Later slots win.
- Flush:
  - spec_map <= cmt_map with the same cycle's commits already applied.
  - ren_vld is cleared.
  - Flush has priority over rename.
- Stall: all registered outputs hold and spec_map holds. Commit still proceeds.
- When not firing and not stalled, ren_vld is cleared.

## Timing
- Rename latency is one cycle: inputs sampled on edge N appear on the outputs after edge N, with ren_vld = inst_vld.
- pr_num_in must be valid in the same cycle as the fire and is consumed at the same edge the free list advances.
- A flush at edge N means instructions renamed at edge N+1 see the committed map.
- If reset asserts mid-operation, both maps and all outputs return to their reset values immediately (asynchronously).

## Configuration
- RAT_FL_EMPTY_STALL_EN defined:
  - blk = list_empty && |(inst_vld & dst_wr).
  - rat_stall = blk. Rename does not fire, pr_need_inst_out is 0, and ren_vld is cleared.
- RAT_FL_EMPTY_STALL_EN undefined:
  - list_empty is ignored and rat_stall is tied to 0.
  - Upstream guarantees free-list availability.

## Test plan
- Reset then idle: src1_arch slot0 = 5 → after one edge, src1_pr slot0 = 5, ren_vld = 4'b0001, old_dst_pr = 0.
- Group of 4 instructions, all writing r3, with pr_num_in = {0x13,0x12,0x11,0x10}, and slot2 src1 = r3:
  - dst_pr = 0x10,0x11,0x12,0x13.
  - old_dst_pr = 3,0x10,0x11,0x12.
  - slot2 src1_pr = 0x11.
  - Next group reading r3 gets 0x13.
- need = 4'b1010 with pr_num_in = {0x23,0x22,0x21,0x20} → pr_need_inst_out = 4'b1010, slot1 dst_pr = 0x20, slot3 dst_pr = 0x21.
- Rename r1→0x10, then commit r1→0x10 plus a rename of r1→0x11, then flush → the next read of r1 gives 0x10.
- Stall held for 3 cycles with changing inputs → outputs and pr_need_inst_out = 0 are unchanged; a commit of r2→0x30 during the stall is visible after a later flush.
- With RAT_FL_EMPTY_STALL_EN defined, list_empty = 1 and one writing slot → rat_stall = 1, pr_need_inst_out = 0, ren_vld = 0; a group with no writes still fires.
